stage_write_md: RTL
===================

Name: stage_write_md

Overview:
- Next-generation writeback stage. Merges in-order MEM/WB results with out-of-order results from the multi-cycle mult/div unit onto one regfile write port and one rstatus write port.
- Buffers mult/div completions in a small FIFO. Arbitrates with fixed priority plus a starvation guard.
- Registers all write-port outputs; these also drive the forwarding path.

Parameters:
- DATA_W, 32, datapath / register width
- REG_W, 5, register index width
- MD_DEPTH, 2, mult/div completion FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, consecutive blocked cycles with FIFO non-empty before a drain stall is requested

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- wb_valid  in  1  MEM/WB slot holds a valid instruction
- opcode  in  5  instruction opcode
- alu_op  in  5  R-type ALU op
- rd  in  REG_W  destination register
- alu_result  in  DATA_W  ALU result
- q_dmem  in  DATA_W  load data
- pc_plus_4  in  DATA_W  link value for jal
- pc_upper_5  in  5  PC[31:27] for setx
- target  in  27  setx immediate
- exception  in  1  arithmetic overflow flag from the main pipe
- md_valid  in  1  mult/div result offered
- md_ready  out  1  FIFO can accept (count < MD_DEPTH)
- md_rd  in  REG_W  mult/div destination
- md_result  in  DATA_W  mult/div result
- md_exception  in  1  mult/div exception
- stall_req  out  1  request that upstream insert a bubble next cycle
- ctrl_writeEnable  out  1  regfile write enable (registered)
- ctrl_writeReg  out  REG_W  regfile write index (registered)
- data_writeReg  out  DATA_W  regfile write data (registered)
- status_we  out  1  rstatus (r30) write enable (registered)
- data_writeStatusReg  out  DATA_W  rstatus data (registered)

Behaviour:
- Reset (reset==0 at posedge): all registered outputs 0, FIFO empty, starve counter 0, stall_req 0. Reset mid-operation discards queued md results.
- Main decode, only when wb_valid:
  - lw: data = q_dmem.
  - jal: index = 31, data = pc_plus_4.
  - add/sub R-type, addi, other ALU ops: data = alu_result, index = rd.
  - R-type with alu_op mul (00110) or div (00111): no main write; the result arrives on the md port.
  - sw, branches, j, jr, bex: no regfile write.
  - main_we = writes && index != 0.
- Main status write:
  - setx: data = {pc_upper_5, target}.
  - add/addi/sub with exception=1: data = 1.
  - add/addi/sub with exception=0: no rstatus write. (Differs from the previous stage, which wrote 0.)
- Latency: decoded writes appear on outputs one cycle after sampling.
- Main slot is busy if main_we or main status write is true. Main always wins.
- md source is the FIFO head, or md_valid directly when the FIFO is empty (bypass). The bypass accepts even when md_ready must stay high.
- md wins a cycle when main is not busy. It writes md_rd/md_result (we suppressed if md_rd==0). If md_exception, it also writes rstatus=1.
- Push: md_valid && md_ready && !(bypass taken). Pop: FIFO non-empty && main not busy. Push and pop in the same cycle keep count unchanged.
- Full FIFO: md_ready=0. The producer must hold md_valid/data stable until accepted.
- Order: FIFO is first-in first-out. Pointers wrap modulo MD_DEPTH.
- Starvation guard: the counter increments each cycle the FIFO is non-empty and main is busy. It clears on pop or when the FIFO is empty.
  - When count reaches STARVE_LIMIT-1, stall_req=1 (registered) for exactly one cycle and the counter clears.
  - Upstream guarantees the next wb_valid=0.
- Same-cycle main and md writes to one register cannot occur. md wins only when main is idle, so the later-arriving write is always last.

Decomposition:
- Shared package: opcode constants (R 00000, addi 00101, lw 01000, sw 00111, jal 00011, setx 10101), alu_op constants (add 00000, sub 00001, mul 00110, div 00111), RSTATUS_IDX=30, LINK_IDX=31.
- One sub-module: md_result_fifo (parametrised depth/width, push/pop/count/full/empty).

Test Plan:
- Reset low 2 cycles during a queued md result -> all outputs 0, md_ready=1, FIFO empty after release.
- lw rd=5, q_dmem=0xDEADBEEF -> next cycle we=1, index 5, data 0xDEADBEEF. jal -> index 31, data=pc_plus_4. addi rd=0 -> we=0.
- addi exception=1 -> status_we=1, data 1. setx pc_upper_5=5'b10001, target=27'h1 -> data 0x88000001. add exception=0 -> status_we=0.
- md_valid rd=7 data 42 while wb_valid=0, FIFO empty -> bypass, next cycle write r7=42, FIFO count stays 0.
- Main writes every cycle while md pushes 3 results, MD_DEPTH=2 -> md_ready low after 2; stall_req pulses after 4 blocked cycles; results drain in push order.
- Push and pop in the same cycle with count=1 -> count stays 1, data order preserved across pointer wrap.

Source files
------------

// File: rtl/stage_write_md_pkg.sv
// Shared decode constants for the writeback stage.
package stage_write_md_pkg;

    typedef enum logic [4:0] {
        OP_R    = 5'b00000,
        OP_JAL  = 5'b00011,
        OP_ADDI = 5'b00101,
        OP_SW   = 5'b00111,
        OP_LW   = 5'b01000,
        OP_SETX = 5'b10101
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_MUL = 5'b00110,
        ALU_DIV = 5'b00111
    } alu_op_e;

    localparam int RSTATUS_IDX = 30;
    localparam int LINK_IDX    = 31;

    // add, sub and addi are the only main-pipe ops that report overflow into rstatus
    function automatic logic is_ovf_op(input logic [4:0] op, input logic [4:0] aop);
        return (op == OP_ADDI) || ((op == OP_R) && ((aop == ALU_ADD) || (aop == ALU_SUB)));
    endfunction

endpackage

// File: rtl/stage_write_md_fifo.sv
// Small power-of-two FIFO holding mult/div completions that lost arbitration.
module md_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/stage_write_md.sv
// Writeback stage: merges in-order MEM/WB results with buffered mult/div completions.
module stage_write_md
    import stage_write_md_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int MD_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [4:0]        opcode,
    input  logic [4:0]        alu_op,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] q_dmem,
    input  logic [DATA_W-1:0] pc_plus_4,
    input  logic [4:0]        pc_upper_5,
    input  logic [26:0]       target,
    input  logic              exception,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_rd,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    output logic              stall_req,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              status_we,
    output logic [DATA_W-1:0] data_writeStatusReg
);
    localparam int FIFO_W = DATA_W + REG_W + 1;
    localparam int SC_W   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    logic              main_wr;
    logic              main_we;
    logic [REG_W-1:0]  main_idx;
    logic [DATA_W-1:0] main_data;
    logic              main_swe;
    logic [DATA_W-1:0] main_sdata;
    logic              main_busy;

    logic [FIFO_W-1:0]       fifo_rdata;
    logic [$clog2(MD_DEPTH):0] fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic              head_exc;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_result;
    logic              sel_exc;
    logic [REG_W-1:0]  sel_rd;
    logic [DATA_W-1:0] sel_result;
    logic              md_win;
    logic              bypass;
    logic [SC_W-1:0]   starve_cnt;

    always_comb begin
        main_wr    = 1'b0;
        main_idx   = '0;
        main_data  = '0;
        main_swe   = 1'b0;
        main_sdata = '0;
        if (wb_valid) begin
            case (opcode)
                OP_R: begin
                    if ((alu_op != ALU_MUL) && (alu_op != ALU_DIV)) begin
                        main_wr   = 1'b1;
                        main_idx  = rd;
                        main_data = alu_result;
                    end
                end
                OP_ADDI: begin
                    main_wr   = 1'b1;
                    main_idx  = rd;
                    main_data = alu_result;
                end
                OP_LW: begin
                    main_wr   = 1'b1;
                    main_idx  = rd;
                    main_data = q_dmem;
                end
                OP_JAL: begin
                    main_wr   = 1'b1;
                    main_idx  = REG_W'(LINK_IDX);
                    main_data = pc_plus_4;
                end
                OP_SETX: begin
                    main_swe   = 1'b1;
                    main_sdata = DATA_W'({pc_upper_5, target});
                end
                default: ;
            endcase
            if (is_ovf_op(opcode, alu_op) && exception) begin
                main_swe   = 1'b1;
                main_sdata = DATA_W'(1);
            end
        end
    end

    assign main_we   = main_wr && (main_idx != '0);
    assign main_busy = main_we || main_swe;

    // An empty FIFO lets a fresh completion go straight to the write port.
    assign {head_exc, head_rd, head_result} = fifo_rdata;
    assign sel_exc    = fifo_empty ? md_exception : head_exc;
    assign sel_rd     = fifo_empty ? md_rd        : head_rd;
    assign sel_result = fifo_empty ? md_result    : head_result;
    assign md_win     = (!fifo_empty || md_valid) && !main_busy;
    assign bypass     = fifo_empty && md_valid && !main_busy;

    assign md_ready  = !fifo_full;
    assign fifo_push = md_valid && md_ready && !bypass;
    assign fifo_pop  = (fifo_count != '0) && !main_busy;

    md_result_fifo #(
        .DEPTH (MD_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({md_exception, md_rd, md_result}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            ctrl_writeEnable    <= 1'b0;
            ctrl_writeReg       <= '0;
            data_writeReg       <= '0;
            status_we           <= 1'b0;
            data_writeStatusReg <= '0;
        end else if (main_busy) begin
            ctrl_writeEnable    <= main_we;
            ctrl_writeReg       <= main_idx;
            data_writeReg       <= main_data;
            status_we           <= main_swe;
            data_writeStatusReg <= main_sdata;
        end else if (md_win) begin
            ctrl_writeEnable    <= (sel_rd != '0);
            ctrl_writeReg       <= sel_rd;
            data_writeReg       <= sel_result;
            status_we           <= sel_exc;
            data_writeStatusReg <= sel_exc ? DATA_W'(1) : '0;
        end else begin
            ctrl_writeEnable    <= 1'b0;
            ctrl_writeReg       <= '0;
            data_writeReg       <= '0;
            status_we           <= 1'b0;
            data_writeStatusReg <= '0;
        end
    end

    // A non-empty FIFO that is not popping means main held the port this cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) begin
            starve_cnt <= '0;
            stall_req  <= 1'b1;
        end else begin
            starve_cnt <= starve_cnt + SC_W'(1);
            stall_req  <= 1'b0;
        end
    end

endmodule
